// File: rtl/digit_serial_adder3_pkg.sv
// digit_serial_adder3_pkg: shared FSM state type, carry width and counter sizing helper
package digit_serial_adder3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // three digits plus a carry of at most 2 never produce a carry above 2
    localparam int CARRY_W = 2;

    // counter width for n states, never narrower than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/digit_adder3.sv
// digit_adder3: adds three DIGIT-bit digits plus a 2-bit carry, producing one digit and a 2-bit carry
module digit_adder3
    import digit_serial_adder3_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0]   a,
    input  logic [DIGIT-1:0]   b,
    input  logic [DIGIT-1:0]   c,
    input  logic [CARRY_W-1:0] cin,
    output logic [DIGIT-1:0]   d,
    output logic [CARRY_W-1:0] cout
);

    logic [DIGIT+1:0] t;

    // full-width digit sum; the top two bits become the next carry
    always_comb begin
        t    = {2'b00, a} + {2'b00, b} + {2'b00, c} + {{DIGIT{1'b0}}, cin};
        d    = t[DIGIT-1:0];
        cout = t[DIGIT+1:DIGIT];
    end

endmodule

// File: rtl/digit_serial_adder3.sv
// digit_serial_adder3: sums three WIDTH-bit operands DIGIT bits per cycle behind valid/ready handshakes
module digit_serial_adder3
    import digit_serial_adder3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = clog2(NDIG);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "digit_serial_adder3: DIGIT must be >=1 and divide WIDTH exactly");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   c_sh_q, c_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH+1:0]   sum_q, sum_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [DIGIT-1:0]   digit;
    logic [CARRY_W-1:0] carry_next;
    logic [WIDTH-1:0]   res_next;
    logic               last;

    digit_adder3 #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sh_q[DIGIT-1:0]),
        .b    (b_sh_q[DIGIT-1:0]),
        .c    (c_sh_q[DIGIT-1:0]),
        .cin  (carry_q),
        .d    (digit),
        .cout (carry_next)
    );

    // new digit enters at the top so the LSB digit ends up at bit 0 after NDIG shifts
    always_comb begin
        res_next = (res_q >> DIGIT) | (WIDTH'(digit) << (WIDTH - DIGIT));
        last     = (cnt_q == CNT_W'(NDIG - 1));
    end

    // next-state and datapath updates for the IDLE/RUN/DONE handshake sequence
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        c_sh_d      = c_sh_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = RUN;
                    a_sh_d     = a;
                    b_sh_d     = b;
                    c_sh_d     = c;
                    res_d      = '0;
                    carry_d    = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                c_sh_d  = c_sh_q >> DIGIT;
                res_d   = res_next;
                carry_d = carry_next;
                cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
                if (last) begin
                    state_d     = DONE;
                    sum_d       = {carry_next, res_next};
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // state and registered outputs; reset wins over any handshake on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            c_sh_q      <= '0;
            res_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            c_sh_q      <= c_sh_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;

endmodule

// File: tb/tb_digit_serial_adder3.sv
// tb_digit_serial_adder3: directed and random checks of three adder configurations against a transaction model
module tb_digit_serial_adder3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv[3], ordy[3], ir[3], ov[3], bz[3];
    logic [15:0] av[3], bv[3], cv[3];
    logic [9:0]  s0, s1;
    logic [17:0] s2;
    logic [17:0] sw[3];

    assign sw[0] = {8'd0, s0};
    assign sw[1] = {8'd0, s1};
    assign sw[2] = s2;

    digit_serial_adder3 #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .c(cv[0][7:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .busy(bz[0])
    );

    digit_serial_adder3 #(.WIDTH(8), .DIGIT(8)) u88 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1][7:0]), .b(bv[1][7:0]), .c(cv[1][7:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .busy(bz[1])
    );

    digit_serial_adder3 #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2]), .b(bv[2]), .c(cv[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .busy(bz[2])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ndig[3] = '{4, 1, 4};
    int wbits[3] = '{8, 8, 16};

    // transaction-level model: an accepted triple becomes visible NDIG edges later, held until taken
    bit     m_busy[3], m_ov[3];
    int     m_cnt[3];
    longint m_pend[3], m_sum[3];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // one clock: advance the model with the inputs seen at the edge, then compare every instance
    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            longint msk;
            msk = (64'd1 << wbits[i]) - 1;
            if (rst) begin
                m_busy[i] = 0; m_ov[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
            end else if (!m_busy[i]) begin
                if (iv[i]) begin
                    m_busy[i] = 1;
                    m_cnt[i]  = ndig[i];
                    m_pend[i] = (longint'(av[i]) & msk) + (longint'(bv[i]) & msk) + (longint'(cv[i]) & msk);
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_sum[i] = m_pend[i];
                    m_ov[i]  = 1;
                end
            end else if (ordy[i]) begin
                m_busy[i] = 0;
                m_ov[i]   = 0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_in_ready[%0d]", i), ir[i], !m_busy[i]);
            chk($sformatf("model_out_valid[%0d]", i), ov[i], m_ov[i]);
            chk($sformatf("model_busy[%0d]", i), bz[i], m_busy[i]);
            chk($sformatf("model_sum[%0d]", i), sw[i], m_sum[i]);
        end
    endtask

    task automatic op(input int i, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      output longint got, output int acc, output int done);
        int t;
        logic was;
        t = 0;
        av[i] = x; bv[i] = y; cv[i] = z; iv[i] = 1'b1;
        do begin
            was = ir[i];
            tick();
            t++;
        end while (!was && t < 50);
        chk("accept", was, 1);
        acc = cyc;
        iv[i] = 1'b0;
        t = 0;
        while (!ov[i] && t < 50) begin
            tick();
            t++;
        end
        chk("result_arrives", ov[i], 1);
        got = sw[i];
        done = cyc;
    endtask

    initial begin
        longint got;
        int acc, done, prev;
        logic [15:0] x, y, z;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 0; ordy[i] = 0; av[i] = 0; bv[i] = 0; cv[i] = 0;
            m_busy[i] = 0; m_ov[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_sum[i] = 0;
        end
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_sum", sw[0], 0);
        rst = 1'b0;
        tick();

        op(0, 16'hFF, 16'hFF, 16'hFF, got, acc, done);
        chk("ff_sum", got, 'h2FD);
        chk("ff_latency", done - acc, 4);
        chk("ff_model_pin", m_sum[0], 'h2FD);
        ordy[0] = 1'b1;
        tick();
        chk("ff_release", ov[0], 0);

        op(0, 16'h00, 16'h00, 16'h00, got, acc, done);
        chk("zero_sum", got, 0);
        prev = acc;
        op(0, 16'h01, 16'h02, 16'h03, got, acc, done);
        chk("small_sum", got, 'h006);
        chk("period_a", acc - prev, 6);
        prev = acc;
        op(0, 16'h80, 16'h80, 16'h80, got, acc, done);
        chk("msb_sum", got, 'h180);
        chk("period_b", acc - prev, 6);
        tick();

        ordy[0] = 1'b0;
        op(0, 16'h12, 16'h34, 16'h56, got, acc, done);
        chk("bp_sum", got, 'h09C);
        av[0] = 16'h77; bv[0] = 16'h88; cv[0] = 16'h99; iv[0] = 1'b1;
        repeat (10) tick();
        chk("bp_sum_hold", sw[0], 'h09C);
        chk("bp_out_valid", ov[0], 1);
        chk("bp_in_ready", ir[0], 0);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp_back_idle", bz[0], 0);
        tick();
        chk("bp_not_captured", bz[0], 0);
        chk("bp_sum_kept", sw[0], 'h09C);

        av[0] = 16'h11; bv[0] = 16'h22; cv[0] = 16'h33; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_out_valid", ov[0], 0);
        chk("abort_in_ready", ir[0], 1);
        chk("abort_busy", bz[0], 0);
        chk("abort_sum", sw[0], 0);
        rst = 1'b0;
        op(0, 16'h05, 16'h06, 16'h07, got, acc, done);
        chk("after_abort_sum", got, 'h012);
        tick();

        ordy[1] = 1'b1;
        op(1, 16'hAA, 16'h55, 16'h01, got, acc, done);
        chk("ndig1_sum", got, 'h100);
        chk("ndig1_latency", done - acc, 1);
        tick();

        ordy[2] = 1'b1;
        op(2, 16'hFFFF, 16'h0001, 16'h8000, got, acc, done);
        chk("w16_sum", got, 'h18000);
        chk("w16_latency", done - acc, 4);
        tick();

        repeat (1000) begin
            x = 16'($urandom_range(0, 65535));
            y = 16'($urandom_range(0, 65535));
            z = 16'($urandom_range(0, 65535));
            ordy[2] = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            op(2, x, y, z, got, acc, done);
            chk("rnd_sum", got, longint'(x) + longint'(y) + longint'(z));
            repeat ($urandom_range(0, 3)) tick();
            ordy[2] = 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder3.md
Name: digit_serial_adder3

Overview:
- Parametrised, sequential successor to the team's combinational 8-bit three-operand adder chain.
- Accepts three WIDTH-bit operands through a valid/ready handshake.
- Sums them DIGIT bits per clock using a registered carry, and returns the full-precision (WIDTH+2)-bit result through a second valid/ready handshake.
- Trades latency for area in datapaths where a, b, c arrive together but throughput is not critical.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥1.
- DIGIT, 2: bits processed per cycle; must divide WIDTH exactly (elaboration-time check; fatal if violated).
- NDIG (derived, not overridable): WIDTH/DIGIT, the cycle count per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b/c valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  WIDTH  operand C
- out_valid  output  1  sum valid
- out_ready  input  1  consumer accepts sum
- sum  output  WIDTH+2  a+b+c, unsigned, no truncation
- busy  output  1  high while in RUN or DONE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0.
  - Internal operand shift registers, carry and digit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b, c into shift registers; clear carry (2 bits) and counter; go to RUN.
- RUN, one digit per cycle:
  - t = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + c_sh[DIGIT-1:0] + carry, computed DIGIT+2 bits wide.
  - Shift t[DIGIT-1:0] into the top of the result register (LSB digit first); carry <= t>>DIGIT; shift the operand registers right by DIGIT; counter++.
  - carry never exceeds 2, since the maximum t is 3·2^DIGIT−1.
  - When counter==NDIG-1, after that cycle's update: sum <= {carry_next, result_next}; go to DONE.
- DONE:
  - out_valid=1; sum holds stable.
  - On out_ready: go to IDLE, out_valid drops next cycle.
- Latency: operands accepted at edge k → out_valid high after edge k+NDIG. Throughput is one operation per NDIG+2 cycles minimum (IDLE accept, NDIG RUN, DONE handshake).
- in_ready=0 in RUN and DONE. in_valid is ignored there; a, b, c may change freely after acceptance.
- sum changes only on the transition into DONE or on rst. It keeps the last result in IDLE.
- out_ready asserted while out_valid=0 has no effect.
- rst asserted mid-RUN or in DONE aborts the operation. All state returns to reset values on that edge, with no partial result emitted.
- rst has priority over every handshake in the same cycle.
- DIGIT==WIDTH (NDIG=1): RUN lasts exactly one cycle; the counter is degenerate (treated as always at terminal count).

Decomposition:
- Package digit_serial_adder3_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - localparam CARRY_W=2.
  - function clog2 for the counter width, max(1, clog2(NDIG)).
- One combinational sub-module, digit_adder3 (parameter DIGIT): inputs three DIGIT-bit digits plus a 2-bit carry in; outputs a DIGIT-bit digit plus a 2-bit carry out. It is the generalisation of the existing per-bit cell.
- The FSM, shift registers and counter live in the top module.

Test Plan:
- WIDTH=8, DIGIT=2: a=0xFF, b=0xFF, c=0xFF accepted at edge k → out_valid rises after edge k+4 with sum=0x2FD; in_ready=0 for edges k+1..exit of DONE.
- a=0, b=0, c=0 → sum=0x000; then a=1, b=2, c=3 → sum=0x006; then a=0x80, b=0x80, c=0x80 → sum=0x180. out_ready is held high throughout, and each op takes 6 cycles accept-to-accept.
- Backpressure: a=0x12, b=0x34, c=0x56 → sum=0x09C. Hold out_ready=0 for 10 cycles while driving in_valid=1 with different operands. Required: sum stays 0x09C, out_valid stays 1, in_ready stays 0, and the second operand set is not captured.
- Reset mid-operation: assert rst on the 2nd RUN cycle. Required next edge: out_valid=0, in_ready=1, busy=0, sum=0. A following op a=5, b=6, c=7 must yield 0x012.
- WIDTH=8, DIGIT=8 (NDIG=1): a=0xAA, b=0x55, c=0x01 → sum=0x100 with out_valid high one edge after acceptance.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, c=0x8000 → sum=0x18000. Also run 1000 random operand triples against a behavioural a+b+c model, with random in_valid/out_ready gaps.
